// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: channel A/D opcodes and a burst-length helper.
package tl_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  localparam int unsigned BeatCntW = 8;

  // Beats in a burst minus one; beat_log is log2 of the beat width in bytes.
  function automatic logic [BeatCntW-1:0] tl_beats_m1(input logic [2:0] size,
                                                      input logic [2:0] beat_log);
    if (size > beat_log) return (BeatCntW'(1) << (size - beat_log)) - BeatCntW'(1);
    return '0;
  endfunction

endpackage

// File: rtl/tl_ram_device_array.sv
// Single-port byte-masked storage with a registered read port (one cycle latency).
module tl_ram_device_array #(
  parameter int DataWidth  = 64,
  parameter int DepthWidth = 12
) (
  input  logic                    clk_i,
  input  logic                    we,
  input  logic [DepthWidth-1:0]   addr,
  input  logic [DataWidth/8-1:0]  be,
  input  logic [DataWidth-1:0]    wdata,
  output logic [DataWidth-1:0]    rdata
);

  logic [DataWidth-1:0] mem [2**DepthWidth];

  // NOTE: storage is deliberately left out of reset so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < DataWidth/8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tl_ram_device.sv
// TileLink-UL RAM device: single-outstanding A/D FSM over a byte-masked array.
// Build option TL_RAM_DEVICE_DENY_EN: out-of-range addresses are denied instead of aliased.
module tl_ram_device
  import tl_pkg::*;
#(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 5,
  parameter int DepthWidth  = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   host_a_valid,
  output logic                   host_a_ready,
  input  logic [2:0]             host_a_opcode,
  input  logic [2:0]             host_a_param,
  input  logic [2:0]             host_a_size,
  input  logic [SourceWidth-1:0] host_a_source,
  input  logic [AddrWidth-1:0]   host_a_address,
  input  logic [DataWidth/8-1:0] host_a_mask,
  input  logic                   host_a_corrupt,
  input  logic [DataWidth-1:0]   host_a_data,
  output logic                   host_d_valid,
  input  logic                   host_d_ready,
  output logic [2:0]             host_d_opcode,
  output logic [2:0]             host_d_param,
  output logic [2:0]             host_d_size,
  output logic [SourceWidth-1:0] host_d_source,
  output logic                   host_d_sink,
  output logic                   host_d_denied,
  output logic                   host_d_corrupt,
  output logic [DataWidth-1:0]   host_d_data
);

  localparam int         ByteOffW = $clog2(DataWidth/8);
  localparam logic [2:0] BeatLog  = 3'(ByteOffW);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_e;
  state_e state_q, state_d;

  logic [BeatCntW-1:0]    cnt_q, beats_m1_q;
  logic [DepthWidth-1:0]  base_q;
  logic [2:0]             size_q;
  logic [SourceWidth-1:0] source_q;
  logic                   denied_q;

  logic                   a_fire, d_fire, last_beat;
  logic                   is_put, is_get, has_data, bad_op, oor;
  logic [BeatCntW-1:0]    req_beats_m1, a_beats_m1;
  logic [DepthWidth-1:0]  req_base;
  logic                   mem_we;
  logic [DepthWidth-1:0]  mem_addr;
  logic [DataWidth-1:0]   mem_rdata;
  logic                   unused_addr;

  assign a_fire    = host_a_valid & host_a_ready;
  assign d_fire    = host_d_valid & host_d_ready;
  assign last_beat = (cnt_q == beats_m1_q);

  assign is_put   = (host_a_opcode == PutFullData) || (host_a_opcode == PutPartialData);
  assign is_get   = (host_a_opcode == Get);
  assign has_data = is_put || (host_a_opcode == ArithmeticData) || (host_a_opcode == LogicalData);
  assign bad_op   = !is_put && !is_get;

  // Refused data-carrying opcodes still drain their full burst; others are one beat.
  assign req_beats_m1 = tl_beats_m1(host_a_size, BeatLog);
  assign a_beats_m1   = (is_get || has_data) ? req_beats_m1 : '0;
  assign req_base     = host_a_address[ByteOffW +: DepthWidth] & ~DepthWidth'(req_beats_m1);

`ifdef TL_RAM_DEVICE_DENY_EN
  assign oor         = |host_a_address[AddrWidth-1:ByteOffW+DepthWidth];
  assign unused_addr = ^{host_a_param, host_a_address[ByteOffW-1:0]};
`else
  assign oor         = 1'b0;
  assign unused_addr = ^{host_a_param, host_a_address[AddrWidth-1:ByteOffW+DepthWidth],
                         host_a_address[ByteOffW-1:0]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (a_fire) begin
        if (is_get)                 state_d = READ;
        else if (a_beats_m1 == '0)  state_d = ACK;
        else                        state_d = WRITE;
      end
      WRITE:   if (a_fire && last_beat) state_d = ACK;
      READ:    if (d_fire && last_beat) state_d = IDLE;
      ACK:     if (d_fire)              state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    host_a_ready  = 1'b0;
    host_d_valid  = 1'b0;
    host_d_opcode = AccessAck;
    case (state_q)
      IDLE, WRITE: host_a_ready = rst_ni;
      READ: begin
        host_d_valid  = 1'b1;
        host_d_opcode = AccessAckData;
      end
      ACK:     host_d_valid = 1'b1;
      default: ;
    endcase
  end

  // Reads look one beat ahead on a D handshake so the next beat lands a cycle later.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = base_q + DepthWidth'(cnt_q);
    case (state_q)
      IDLE: begin
        mem_addr = req_base;
        mem_we   = a_fire & is_put & ~host_a_corrupt & ~oor;
      end
      WRITE:   mem_we = a_fire & ~host_a_corrupt & ~denied_q;
      READ:    if (d_fire) mem_addr = base_q + DepthWidth'(cnt_q + BeatCntW'(1));
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      beats_m1_q <= '0;
      base_q     <= '0;
      size_q     <= '0;
      source_q   <= '0;
      denied_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (a_fire) begin
          size_q     <= host_a_size;
          source_q   <= host_a_source;
          base_q     <= req_base;
          beats_m1_q <= a_beats_m1;
          denied_q   <= bad_op | oor;
          cnt_q      <= is_get ? '0 : BeatCntW'(1);
        end
        WRITE:   if (a_fire) cnt_q <= cnt_q + BeatCntW'(1);
        READ:    if (d_fire) cnt_q <= last_beat ? '0 : cnt_q + BeatCntW'(1);
        ACK:     if (d_fire) cnt_q <= '0;
        default: ;
      endcase
    end
  end

  tl_ram_device_array #(
    .DataWidth (DataWidth),
    .DepthWidth(DepthWidth)
  ) u_array (
    .clk_i(clk_i),
    .we   (mem_we),
    .addr (mem_addr),
    .be   (host_a_mask),
    .wdata(host_a_data),
    .rdata(mem_rdata)
  );

  assign host_d_param   = '0;
  assign host_d_sink    = 1'b0;
  assign host_d_corrupt = 1'b0;
  assign host_d_size    = size_q;
  assign host_d_source  = source_q;
  assign host_d_denied  = denied_q;
  assign host_d_data    = (state_q == READ && !denied_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_tl_ram_device.sv
// Self-checking bench for tl_ram_device: byte-level memory model plus D-channel scoreboard.
module tb_tl_ram_device;

  localparam int DW = 64;
  localparam int AW = 56;
  localparam int SW = 5;
  localparam int DEP = 12;
  localparam int WORDS = 1 << DEP;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          host_a_valid = 1'b0;
  logic          host_a_ready;
  logic [2:0]    host_a_opcode = '0;
  logic [2:0]    host_a_param = '0;
  logic [2:0]    host_a_size = '0;
  logic [SW-1:0] host_a_source = '0;
  logic [AW-1:0] host_a_address = '0;
  logic [DW/8-1:0] host_a_mask = '0;
  logic          host_a_corrupt = 1'b0;
  logic [DW-1:0] host_a_data = '0;
  logic          host_d_valid;
  logic          host_d_ready = 1'b1;
  logic [2:0]    host_d_opcode, host_d_param, host_d_size;
  logic [SW-1:0] host_d_source;
  logic          host_d_sink, host_d_denied, host_d_corrupt;
  logic [DW-1:0] host_d_data;

  always #5 clk_i = ~clk_i;

  tl_ram_device #(
    .DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .DepthWidth(DEP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
    .host_a_opcode(host_a_opcode), .host_a_param(host_a_param),
    .host_a_size(host_a_size), .host_a_source(host_a_source),
    .host_a_address(host_a_address), .host_a_mask(host_a_mask),
    .host_a_corrupt(host_a_corrupt), .host_a_data(host_a_data),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
    .host_d_opcode(host_d_opcode), .host_d_param(host_d_param),
    .host_d_size(host_d_size), .host_d_source(host_d_source),
    .host_d_sink(host_d_sink), .host_d_denied(host_d_denied),
    .host_d_corrupt(host_d_corrupt), .host_d_data(host_d_data)
  );

  typedef struct {
    logic [2:0]    op;
    logic [2:0]    size;
    logic [SW-1:0] src;
    logic          denied;
    logic [DW-1:0] data;
  } d_exp_t;

  d_exp_t        exp_q[$];
  logic [DW-1:0] model_mem [WORDS];
  logic [DW-1:0] rd_log[$];
  logic [DW-1:0] wbuf [16];
  logic          last_denied = 1'b0;
  logic [SW-1:0] last_src = '0;
  bit            toggle_ready = 1'b0;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int beats_of(input logic [2:0] op, input logic [2:0] size);
    if (op <= 3'd4 && size > 3) return 1 << (size - 3);
    return 1;
  endfunction

  function automatic int word_base(input logic [AW-1:0] addr, input logic [2:0] size);
    int w, nb;
    w  = int'((addr / 8) % WORDS);
    nb = (size > 3) ? (1 << (size - 3)) : 1;
    return w - (w % nb);
  endfunction

  function automatic bit addr_oor(input logic [AW-1:0] addr);
`ifdef TL_RAM_DEVICE_DENY_EN
    return addr >= AW'(WORDS * 8);
`else
    return (addr != addr);
`endif
  endfunction

  task automatic model_write(input int idx, input logic [7:0] mask, input logic [DW-1:0] data);
    for (int b = 0; b < 8; b++)
      if (mask[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic a_beat(input logic [2:0] op, input logic [2:0] size, input logic [AW-1:0] addr,
                        input logic [SW-1:0] src, input logic [7:0] mask, input logic corrupt,
                        input logic [DW-1:0] data);
    int n = 0;
    host_a_valid = 1'b1; host_a_opcode = op; host_a_size = size; host_a_address = addr;
    host_a_source = src; host_a_mask = mask; host_a_corrupt = corrupt; host_a_data = data;
    while (!host_a_ready && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL a_ready_timeout: got 0 want 1");
    end
    @(negedge clk_i);
    host_a_valid = 1'b0; host_a_corrupt = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL d_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic put_txn(input logic [2:0] op, input logic [2:0] size, input logic [AW-1:0] addr,
                         input logic [SW-1:0] src, input logic [7:0] mask, input logic corrupt);
    int nb, base;
    d_exp_t e;
    nb = beats_of(op, size);
    base = word_base(addr, size);
    e.op = 3'd0; e.size = size; e.src = src; e.data = '0;
    e.denied = !(op == 3'd0 || op == 3'd1) || addr_oor(addr);
    exp_q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      a_beat(op, size, addr, src, mask, corrupt, wbuf[i]);
      if (!e.denied && !corrupt) model_write((base + i) % WORDS, mask, wbuf[i]);
    end
    wait_idle();
  endtask

  task automatic get_txn(input logic [2:0] size, input logic [AW-1:0] addr, input logic [SW-1:0] src);
    int nb, base;
    bit oor;
    d_exp_t e;
    nb = beats_of(3'd4, size);
    base = word_base(addr, size);
    oor = addr_oor(addr);
    for (int i = 0; i < nb; i++) begin
      e.op = 3'd1; e.size = size; e.src = src; e.denied = oor;
      e.data = oor ? '0 : model_mem[(base + i) % WORDS];
      exp_q.push_back(e);
    end
    rd_log.delete();
    a_beat(3'd4, size, addr, src, 8'hFF, 1'b0, '0);
    wait_idle();
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      host_d_ready = toggle_ready ? ~host_d_ready : 1'b1;
    end
  end

  // Scoreboard: every D handshake is matched against the next expected beat.
  initial begin
    logic stalled;
    logic [DW-1:0] held;
    d_exp_t e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk_i);
      #2;
      if (stalled) begin
        check("d_hold_valid", host_d_valid, 1);
        check("d_hold_data", host_d_data, held);
      end
      if (host_d_valid) check("a_ready_blocked", host_a_ready, 0);
      if (host_d_valid && host_d_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_d: got opcode %0d want no beat", host_d_opcode);
        end else begin
          e = exp_q.pop_front();
          check("d_opcode", host_d_opcode, e.op);
          check("d_size", host_d_size, e.size);
          check("d_source", host_d_source, e.src);
          check("d_denied", host_d_denied, e.denied);
          check("d_fixed_zero", {host_d_param, host_d_sink, host_d_corrupt}, 0);
          if (e.op == 3'd1) begin
            check("d_data", host_d_data, e.data);
            rd_log.push_back(host_d_data);
          end
          last_denied = host_d_denied;
          last_src = host_d_source;
        end
      end
      stalled = host_d_valid && !host_d_ready;
      held = host_d_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_a_ready", host_a_ready, 0);
    check("reset_d_valid", host_d_valid, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post_reset_a_ready", host_a_ready, 1);
    check("post_reset_d_valid", host_d_valid, 0);
    @(negedge clk_i);

    // Word 0 seeded so an aliased access has something known to read.
    wbuf[0] = 64'hCAFE_F00D_DEAD_BEEF;
    put_txn(3'd0, 3'd3, 56'h0, 5'd1, 8'hFF, 1'b0);

    wbuf[0] = 64'h1122_3344_5566_7788;
    put_txn(3'd0, 3'd3, 56'h40, 5'd2, 8'hFF, 1'b0);
    check("put_full_denied", last_denied, 0);
    get_txn(3'd3, 56'h40, 5'd3);
    check("get_after_put", rd_log[0], 64'h1122_3344_5566_7788);

    wbuf[0] = 64'h0000_0000_FFFF_FFFF;
    put_txn(3'd1, 3'd3, 56'h40, 5'd4, 8'h0F, 1'b0);
    get_txn(3'd3, 56'h40, 5'd5);
    check("get_after_partial", rd_log[0], 64'h1122_3344_FFFF_FFFF);

    wbuf[0] = 64'h0;
    put_txn(3'd2, 3'd3, 56'h40, 5'd6, 8'hFF, 1'b0);
    check("arith_denied", last_denied, 1);
    get_txn(3'd3, 56'h40, 5'd7);
    check("arith_no_write", rd_log[0], 64'h1122_3344_FFFF_FFFF);

    wbuf[0] = 64'h0123_4567_89AB_CDEF;
    put_txn(3'd0, 3'd3, 56'h48, 5'd8, 8'hFF, 1'b0);
    wbuf[0] = 64'hDEAD_DEAD_DEAD_DEAD;
    put_txn(3'd0, 3'd3, 56'h48, 5'd9, 8'hFF, 1'b1);
    get_txn(3'd3, 56'h48, 5'd10);
    check("corrupt_not_written", rd_log[0], 64'h0123_4567_89AB_CDEF);

    for (int i = 0; i < 8; i++) wbuf[i] = 64'h0100_0000_0000_0000 | 64'(i);
    put_txn(3'd0, 3'd6, 56'h100, 5'd11, 8'hFF, 1'b0);
    for (int i = 0; i < 2; i++) wbuf[i] = 64'h0;
    put_txn(3'd3, 3'd4, 56'h100, 5'd12, 8'hFF, 1'b0);
    check("logical_drain_denied", last_denied, 1);

    toggle_ready = 1'b1;
    get_txn(3'd6, 56'h100, 5'h13);
    toggle_ready = 1'b0;
    check("burst_beats", rd_log.size(), 8);
    check("burst_first", rd_log[0], 64'h0100_0000_0000_0000);
    check("burst_last", rd_log[7], 64'h0100_0000_0000_0007);
    check("burst_source", last_src, 5'h13);

    get_txn(3'd6, 56'h108, 5'd14);
    check("unaligned_burst_base", rd_log[0], 64'h0100_0000_0000_0000);

    get_txn(3'd3, 56'h10000, 5'd15);
`ifdef TL_RAM_DEVICE_DENY_EN
    check("oor_denied", last_denied, 1);
    check("oor_data", rd_log[0], 64'h0);
`else
    check("alias_denied", last_denied, 0);
    check("alias_data", rd_log[0], 64'hCAFE_F00D_DEAD_BEEF);
`endif

    // Burst cut short by reset: only the accepted beats reach storage.
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hAAAA_0000_0000_0000 | 64'(i);
    put_txn(3'd0, 3'd6, 56'h200, 5'd16, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a_beat(3'd0, 3'd6, 56'h200, 5'd17, 8'hFF, 1'b0, 64'h5555_0000_0000_0000 | 64'(i));
      model_write(word_base(56'h200, 3'd6) + i, 8'hFF, 64'h5555_0000_0000_0000 | 64'(i));
    end
    rst_ni = 1'b0;
    #1;
    check("midburst_reset_a_ready", host_a_ready, 0);
    check("midburst_reset_d_valid", host_d_valid, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("midburst_idle_a_ready", host_a_ready, 1);
    check("midburst_idle_d_valid", host_d_valid, 0);
    @(negedge clk_i);
    get_txn(3'd6, 56'h200, 5'd18);
    check("midburst_beats", rd_log.size(), 8);
    check("midburst_beat3_new", rd_log[3], 64'h5555_0000_0000_0003);
    check("midburst_beat4_old", rd_log[4], 64'hAAAA_0000_0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_ram_device.md
TL_RAM_DEVICE -- requirements
Module: tl_ram_device

Interface
REQ-001 SHALL have parameter DataWidth, default 64, beat width in bits (power of two, at least 32).
REQ-002 SHALL have parameter AddrWidth, default 56, TileLink address width.
REQ-003 SHALL have parameter SourceWidth, default 5, A/D source ID width.
REQ-004 SHALL have parameter DepthWidth, default 12; storage holds 2**DepthWidth beats.
REQ-005 SHALL have port clk_i, input, 1, sole clock.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port host_a_valid, input, 1, A request valid.
REQ-008 SHALL have port host_a_ready, output, 1, A request ready.
REQ-009 SHALL have port host_a_opcode, input, 3, A opcode.
REQ-010 SHALL have port host_a_param, input, 3, A param (ignored).
REQ-011 SHALL have port host_a_size, input, 3, log2 transfer bytes.
REQ-012 SHALL have port host_a_source, input, SourceWidth, requester ID.
REQ-013 SHALL have port host_a_address, input, AddrWidth, byte address.
REQ-014 SHALL have port host_a_mask, input, DataWidth/8, byte enables.
REQ-015 SHALL have port host_a_corrupt, input, 1, beat corrupt flag.
REQ-016 SHALL have port host_a_data, input, DataWidth, write data.
REQ-017 SHALL have port host_d_valid, output, 1, D response valid.
REQ-018 SHALL have port host_d_ready, input, 1, D response ready.
REQ-019 SHALL have port host_d_opcode, output, 3, AccessAck=0 or AccessAckData=1.
REQ-020 SHALL have port host_d_param, output, 3, always 0.
REQ-021 SHALL have port host_d_size, output, 3, echoed request size.
REQ-022 SHALL have port host_d_source, output, SourceWidth, echoed request source.
REQ-023 SHALL have port host_d_sink, output, 1, always 0.
REQ-024 SHALL have port host_d_denied, output, 1, request refused.
REQ-025 SHALL have port host_d_corrupt, output, 1, always 0.
REQ-026 SHALL have port host_d_data, output, DataWidth, read data.

Function
REQ-027 SHALL implement states IDLE, WRITE, READ, ACK, with exactly one transaction outstanding.
REQ-028 Beat count SHALL be 2**size/(DataWidth/8) when size exceeds log2(DataWidth/8), else 1; low address bits within the burst are ignored.
REQ-029 Beat index SHALL be the address word index plus the beat counter, wrapping modulo 2**DepthWidth.
REQ-030 host_a_ready SHALL be 1 only in IDLE and WRITE, so no new request is accepted in the cycle of the final D handshake.
REQ-031 PutFullData (0) and PutPartialData (1): each A beat SHALL write the masked bytes in its handshake cycle; beats with host_a_corrupt=1 are not written.
REQ-032 After the last put beat, SHALL enter ACK and drive AccessAck with latched size/source on the next cycle; on host_d_ready, SHALL return to IDLE.
REQ-033 Get (4): after acceptance, SHALL enter READ with AccessAckData beat 0 valid on the next cycle; each D handshake SHALL advance the counter; the last handshake SHALL return to IDLE.
REQ-034 host_d_data SHALL remain stable while host_d_valid=1 and host_d_ready=0.
REQ-035 Any other opcode SHALL produce no storage change, a single AccessAck beat with denied=1, and the remaining A beats drained.

Reset
REQ-036 On rst_ni low, SHALL enter IDLE with host_d_valid=0, host_a_ready=0 during reset and 1 after, counters 0, and storage contents unchanged; a reset mid-burst aborts the burst.

Configuration
REQ-037 With TL_RAM_DEVICE_DENY_EN defined, an address above storage range SHALL be answered with denied=1, zero data, no write, and the full beat count.
REQ-038 Without TL_RAM_DEVICE_DENY_EN, upper address bits SHALL be ignored (aliasing) and denied SHALL be 0 except for REQ-035.

Structure
REQ-039 TileLink opcode enums SHALL come from the shared tl_pkg; the FSM state typedef stays local.
REQ-040 The byte-masked single-port storage SHALL be the sub-module tl_ram_device_array with a registered read (1-cycle latency).

Verification
REQ-041 PutFullData size 3 at 0x40, data 0x1122334455667788 -> one AccessAck, denied=0; a subsequent Get size 3 returns that data.
REQ-042 PutPartialData mask 0x0F with data 0xFFFFFFFF over 0x1122334455667788 -> Get returns 0x11223344FFFFFFFF.
REQ-043 Get size 6 at 0x100 with host_d_ready toggling every cycle -> 8 AccessAckData beats in order, data stable while stalled, source echoed.
REQ-044 Opcode 2 (ArithmeticData) size 3 -> AccessAck denied=1, storage unchanged.
REQ-045 DENY_EN build, Get at 0x10000 (DepthWidth 12) -> denied=1, data 0; non-DENY build -> aliases to 0x0.
REQ-046 Assert rst_ni after the 4th beat of an 8-beat Put -> IDLE, host_d_valid=0, first 4 beats written, next request served normally.
